// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_scoreboard_if                                         |
// | Description : ID-stage request / issue-control bundle for the hazard       |
// |               scoreboard. The master side is the ID stage / pipeline       |
// |               glue, the slave side is the scoreboard itself.               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface hazard_scoreboard_if;
    logic        i_id_valid;
    logic [4:0]  i_id_rs1_addr;
    logic        i_id_rs1_used;
    logic [4:0]  i_id_rs2_addr;
    logic        i_id_rs2_used;
    logic [4:0]  i_id_rd_addr;
    logic        i_id_rd_wren;
    logic        i_ex_br_taken;
    logic        o_stall;
    logic        o_flush_if_id;
    logic        o_flush_id_ex;
    logic        o_issue;
    logic [31:0] o_busy_mask;
    logic        o_redirect;

    modport master (
        output i_id_valid, i_id_rs1_addr, i_id_rs1_used, i_id_rs2_addr,
               i_id_rs2_used, i_id_rd_addr, i_id_rd_wren, i_ex_br_taken,
        input  o_stall, o_flush_if_id, o_flush_id_ex, o_issue,
               o_busy_mask, o_redirect
    );

    modport slave (
        input  i_id_valid, i_id_rs1_addr, i_id_rs1_used, i_id_rs2_addr,
               i_id_rs2_used, i_id_rd_addr, i_id_rd_wren, i_ex_br_taken,
        output o_stall, o_flush_if_id, o_flush_id_ex, o_issue,
               o_busy_mask, o_redirect
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_scoreboard                                            |
// | Description : Issue controller for a non-forwarding RV32I pipeline.        |
// |               Per-register countdown scoreboard for RAW stalls plus a      |
// |               redirect FSM that flushes wrong-path fetches after a taken   |
// |               branch/jump resolved in EX.                                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module hazard_scoreboard #(
    parameter int unsigned WB_LAT    = 3,   // issue -> rd readable in ID, 1..7
    parameter int unsigned REDIR_CYC = 1    // extra flush cycles after taken, 0..7
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst_n,
    hazard_scoreboard_if.slave bus
);

    localparam logic [2:0] c_wb_lat    = 3'(WB_LAT);
    localparam logic [2:0] c_redir_cyc = 3'(REDIR_CYC);
    localparam logic       c_redir_en  = (REDIR_CYC != 0);

    localparam logic [0:0] c_st_idle     = 1'b0;
    localparam logic [0:0] c_st_redirect = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [2:0]  r_rcnt;
    logic [2:0]  w_rcnt_nxt;
    logic [31:0] w_busy;
    logic        w_hz;
    logic        w_flush;
    logic        w_issue;

    // x0 is hard-wired zero and can never be pending
    assign w_busy[0] = 1'b0;

    // One countdown per architectural register; nonzero means a write is in flight
    generate
        for (genvar r = 1; r < 32; r++) begin : g_cnt
            logic [2:0] r_cnt;

            // Issue of a writer reloads the counter, otherwise it drains towards zero
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_cnt <= 3'd0;
                end else if (w_issue && bus.i_id_rd_wren && (bus.i_id_rd_addr == 5'(r))) begin
                    r_cnt <= c_wb_lat;
                end else if (r_cnt != 3'd0) begin
                    r_cnt <= r_cnt - 3'd1;
                end
            end

            assign w_busy[r] = (r_cnt != 3'd0);
        end
    endgenerate

    // A source read of a pending register is a RAW hazard; x0 never counts
    assign w_hz = bus.i_id_valid &
                  ((bus.i_id_rs1_used & (bus.i_id_rs1_addr != 5'd0) & w_busy[bus.i_id_rs1_addr]) |
                   (bus.i_id_rs2_used & (bus.i_id_rs2_addr != 5'd0) & w_busy[bus.i_id_rs2_addr]));

    assign w_flush = bus.i_ex_br_taken | (r_state == c_st_redirect);
    assign w_issue = bus.i_id_valid & ~w_hz & ~w_flush & i_rst_n;

    // Redirect FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= c_st_idle;
            r_rcnt  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rcnt  <= w_rcnt_nxt;
        end
    end

    // Redirect FSM next state: a new taken branch always restarts the flush window
    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        case (r_state)
            c_st_idle: begin
                if (bus.i_ex_br_taken && c_redir_en) begin
                    w_state_nxt = c_st_redirect;
                    w_rcnt_nxt  = c_redir_cyc;
                end
            end
            c_st_redirect: begin
                if (bus.i_ex_br_taken) begin
                    w_rcnt_nxt = c_redir_cyc;
                end else if (r_rcnt <= 3'd1) begin
                    w_state_nxt = c_st_idle;
                    w_rcnt_nxt  = 3'd0;
                end else begin
                    w_rcnt_nxt = r_rcnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_rcnt_nxt  = 3'd0;
            end
        endcase
    end

    // Pipeline control outputs; flush wins over stall
    always_comb begin
        bus.o_stall       = w_hz & ~w_flush;
        bus.o_flush_if_id = w_flush;
        bus.o_flush_id_ex = w_flush | w_hz;
        bus.o_issue       = w_issue;
        bus.o_busy_mask   = w_busy;
        bus.o_redirect    = (r_state == c_st_redirect);
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hazard_scoreboard                                         |
// | Description : Directed self-checking bench for hazard_scoreboard with      |
// |               WB_LAT=3, REDIR_CYC=1.                                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_hazard_scoreboard;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    hazard_scoreboard_if bus ();

    hazard_scoreboard #(
        .WB_LAT    (3),
        .REDIR_CYC (1)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control outputs packed as {stall, flush_if_id, flush_id_ex, issue, redirect}
    function automatic logic [4:0] ctl();
        return {bus.o_stall, bus.o_flush_if_id, bus.o_flush_id_ex, bus.o_issue, bus.o_redirect};
    endfunction

    localparam logic [4:0] c_none  = 5'b00000;
    localparam logic [4:0] c_iss   = 5'b00010;
    localparam logic [4:0] c_stl   = 5'b10100;
    localparam logic [4:0] c_brf   = 5'b01100;
    localparam logic [4:0] c_redir = 5'b01101;

    // Advance past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply an ID/EX input pattern and let combinational outputs settle
    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic w, input logic br);
        bus.i_id_valid    = v;
        bus.i_id_rs1_addr = rs1;
        bus.i_id_rs1_used = u1;
        bus.i_id_rs2_addr = rs2;
        bus.i_id_rs2_used = u2;
        bus.i_id_rd_addr  = rd;
        bus.i_id_rd_wren  = w;
        bus.i_ex_br_taken = br;
        #2;
    endtask

    task automatic test_reset();
        logic [4:0] o;
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        // load cnt[5] = 3
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        o = ctl();
        n_vec++;
        if (o !== c_iss) begin n_err++; $display("FAIL reset_load_issue: got %b expected %b", o, c_iss); end
        tick();
        // taken branch pushes FSM into REDIRECT
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        n_vec++;
        if (bus.o_busy_mask !== 32'h0000_0020) begin n_err++; $display("FAIL reset_pre_busy: got %h expected %h", bus.o_busy_mask, 32'h0000_0020); end
        n_vec++;
        if (bus.o_redirect !== 1'b1) begin n_err++; $display("FAIL reset_pre_redirect: got %b expected %b", bus.o_redirect, 1'b1); end
        // reset mid-countdown and mid-redirect
        rst_n = 1'b0;
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        n_vec++;
        if (bus.o_busy_mask !== 32'h0) begin n_err++; $display("FAIL reset_busy: got %h expected %h", bus.o_busy_mask, 32'h0); end
        o = ctl();
        n_vec++;
        if (o !== c_none) begin n_err++; $display("FAIL reset_ctl: got %b expected %b", o, c_none); end
        rst_n = 1'b1;
        #1;
        o = ctl();
        n_vec++;
        if (o !== c_iss) begin n_err++; $display("FAIL reset_release_issue: got %b expected %b", o, c_iss); end
        tick();
    endtask

    task automatic test_raw();
        logic [4:0] o;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        o = ctl();
        n_vec++;
        if (o !== c_iss) begin n_err++; $display("FAIL raw_producer: got %b expected %b", o, c_iss); end
        tick();
        for (int c = 1; c <= 3; c++) begin
            drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
            o = ctl();
            n_vec++;
            if (o !== c_stl) begin n_err++; $display("FAIL raw_stall_c%0d: got %b expected %b", c, o, c_stl); end
            n_vec++;
            if (bus.o_busy_mask !== 32'h0000_0020) begin n_err++; $display("FAIL raw_busy_c%0d: got %h expected %h", c, bus.o_busy_mask, 32'h0000_0020); end
            tick();
        end
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        o = ctl();
        n_vec++;
        if (o !== c_iss) begin n_err++; $display("FAIL raw_issue_c4: got %b expected %b", o, c_iss); end
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        n_vec++;
        if (bus.o_busy_mask !== 32'h0000_0040) begin n_err++; $display("FAIL raw_busy_rd6: got %h expected %h", bus.o_busy_mask, 32'h0000_0040); end
        tick();
        tick();
        tick();
        n_vec++;
        if (bus.o_busy_mask !== 32'h0) begin n_err++; $display("FAIL raw_drain: got %h expected %h", bus.o_busy_mask, 32'h0); end
    endtask

    task automatic test_x0();
        logic [4:0] o;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        o = ctl();
        n_vec++;
        if (o !== c_iss) begin n_err++; $display("FAIL x0_write_issue: got %b expected %b", o, c_iss); end
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        o = ctl();
        n_vec++;
        if (o !== c_iss) begin n_err++; $display("FAIL x0_read_nostall: got %b expected %b", o, c_iss); end
        n_vec++;
        if (bus.o_busy_mask !== 32'h0) begin n_err++; $display("FAIL x0_busy: got %h expected %h", bus.o_busy_mask, 32'h0); end
        tick();
    endtask

    task automatic test_branch_vs_stall();
        logic [4:0] o;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        tick();
        // hazard on rs2 and taken branch in the same cycle
        drive(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1);
        o = ctl();
        n_vec++;
        if (o !== c_brf) begin n_err++; $display("FAIL brs_taken: got %b expected %b", o, c_brf); end
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
        o = ctl();
        n_vec++;
        if (o !== c_redir) begin n_err++; $display("FAIL brs_redirect: got %b expected %b", o, c_redir); end
        n_vec++;
        if (bus.o_busy_mask !== 32'h0000_0200) begin n_err++; $display("FAIL brs_busy_in_flush: got %h expected %h", bus.o_busy_mask, 32'h0000_0200); end
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
        o = ctl();
        n_vec++;
        if (o !== c_stl) begin n_err++; $display("FAIL brs_idle_stall: got %b expected %b", o, c_stl); end
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
        o = ctl();
        n_vec++;
        if (o !== c_iss) begin n_err++; $display("FAIL brs_issue: got %b expected %b", o, c_iss); end
        tick();
    endtask

    task automatic test_reload();
        logic [4:0] o;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        o = ctl();
        n_vec++;
        if (o !== c_iss) begin n_err++; $display("FAIL reload_rewrite_issue: got %b expected %b", o, c_iss); end
        tick();
        for (int c = 1; c <= 3; c++) begin
            drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
            o = ctl();
            n_vec++;
            if (o !== c_stl) begin n_err++; $display("FAIL reload_stall_c%0d: got %b expected %b", c, o, c_stl); end
            tick();
        end
        drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        o = ctl();
        n_vec++;
        if (o !== c_iss) begin n_err++; $display("FAIL reload_issue: got %b expected %b", o, c_iss); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0] o;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        o = ctl();
        n_vec++;
        if (o !== c_brf) begin n_err++; $display("FAIL b2b_first: got %b expected %b", o, c_brf); end
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        o = ctl();
        n_vec++;
        if (o !== c_redir) begin n_err++; $display("FAIL b2b_second: got %b expected %b", o, c_redir); end
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        o = ctl();
        n_vec++;
        if (o !== c_redir) begin n_err++; $display("FAIL b2b_reloaded: got %b expected %b", o, c_redir); end
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        o = ctl();
        n_vec++;
        if (o !== c_iss) begin n_err++; $display("FAIL b2b_resume: got %b expected %b", o, c_iss); end
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        o = ctl();
        n_vec++;
        if (o !== c_none) begin n_err++; $display("FAIL b2b_idle: got %b expected %b", o, c_none); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        test_reset();
        test_raw();
        test_x0();
        test_branch_vs_stall();
        test_reload();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
